// File: rtl/note_block_plotter_if.sv
// Pixel-plotter bus: frame request and note table in, registered pixel stream out.
// The master drives requests and observes pixels; the slave is the plotter.
interface note_block_plotter_if #(
  parameter int NUM_NOTES = 15
) ();

  logic                   start;
  logic                   mode;
  logic [NUM_NOTES*8-1:0] note_x;
  logic [NUM_NOTES*3-1:0] note_colour;
  logic [NUM_NOTES-1:0]   note_valid;
  logic [7:0]             out_x;
  logic [6:0]             out_y;
  logic [2:0]             colour;
  logic                   plot;
  logic                   busy;
  logic                   done;

  modport master (
    output start, mode, note_x, note_colour, note_valid,
    input  out_x, out_y, colour, plot, busy, done
  );

  modport slave (
    input  start, mode, note_x, note_colour, note_valid,
    output out_x, out_y, colour, plot, busy, done
  );

endinterface

// File: rtl/note_block_plotter.sv
// Draws one BLK_W x BLK_H block per valid note, or clears the whole screen, as a pixel stream.
// Optional feature macro NOTE_OUTLINE_EN: paints the block border white (3'b111).
module note_block_plotter #(
  parameter int         NUM_NOTES = 15,
  parameter int         BLK_W     = 4,
  parameter int         BLK_H     = 4,
  parameter int         NOTE_Y    = 110,
  parameter int         SCR_W     = 160,
  parameter int         SCR_H     = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input logic CLK,
  input logic reset,
  note_block_plotter_if.slave bus
);

  localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam int COL_W = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int ROW_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_NOTES - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(BLK_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(BLK_H - 1);
  localparam logic [7:0]       CLR_X_LAST = 8'(SCR_W - 1);
  localparam logic [6:0]       CLR_Y_LAST = 7'(SCR_H - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    CLEAR  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [NUM_NOTES*8-1:0] note_x_q, note_x_d;
  logic [NUM_NOTES*3-1:0] note_colour_q, note_colour_d;
  logic [NUM_NOTES-1:0]   note_valid_q, note_valid_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [7:0]             clr_x_q, clr_x_d;
  logic [6:0]             clr_y_q, clr_y_d;
  logic [7:0]             out_x_q, out_x_d;
  logic [6:0]             out_y_q, out_y_d;
  logic [2:0]             colour_q, colour_d;
  logic                   plot_q, plot_d;
  logic                   done_q, done_d;

  logic [NUM_NOTES*8-1:0] src_x;
  logic [NUM_NOTES*3-1:0] src_colour;
  logic [NUM_NOTES-1:0]   src_valid;
  logic [7:0]             x_arr [NUM_NOTES];
  logic [2:0]             c_arr [NUM_NOTES];
  logic                   emit_draw;
  logic                   emit_clear;
  logic [8:0]             x_sum;
  logic [8:0]             y_sum;

  // The first pixel is produced on the start edge, before the note table is captured.
  always_comb begin
    src_x      = note_x_q;
    src_colour = note_colour_q;
    src_valid  = note_valid_q;
    if (state_q == IDLE) begin
      src_x      = bus.note_x;
      src_colour = bus.note_colour;
      src_valid  = bus.note_valid;
    end
    for (int i = 0; i < NUM_NOTES; i++) begin
      x_arr[i] = src_x[i*8 +: 8];
      c_arr[i] = src_colour[i*3 +: 3];
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    note_x_d      = note_x_q;
    note_colour_d = note_colour_q;
    note_valid_d  = note_valid_q;
    idx_d         = idx_q;
    col_d         = col_q;
    row_d         = row_q;
    clr_x_d       = clr_x_q;
    clr_y_d       = clr_y_q;
    out_x_d       = out_x_q;
    out_y_d       = out_y_q;
    colour_d      = colour_q;
    plot_d        = 1'b0;
    done_d        = 1'b0;
    emit_draw     = 1'b0;
    emit_clear    = 1'b0;
    x_sum         = '0;
    y_sum         = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d        = bus.mode;
          note_x_d      = bus.note_x;
          note_colour_d = bus.note_colour;
          note_valid_d  = bus.note_valid;
          idx_d         = '0;
          col_d         = '0;
          row_d         = '0;
          clr_x_d       = '0;
          clr_y_d       = '0;
          if (bus.mode) begin
            state_d    = CLEAR;
            emit_clear = 1'b1;
          end else begin
            state_d   = DRAW;
            emit_draw = 1'b1;
          end
        end
      end

      DRAW: begin
        // An invalid note occupies exactly one cycle, so it ends as soon as it starts.
        if (!src_valid[idx_q] || (col_q == COL_LAST && row_q == ROW_LAST)) begin
          if (idx_q == IDX_LAST) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            col_d     = '0;
            row_d     = '0;
            emit_draw = 1'b1;
          end
        end else if (col_q == COL_LAST) begin
          col_d     = '0;
          row_d     = row_q + ROW_W'(1);
          emit_draw = 1'b1;
        end else begin
          col_d     = col_q + COL_W'(1);
          emit_draw = 1'b1;
        end
      end

      CLEAR: begin
        if (clr_x_q == CLR_X_LAST && clr_y_q == CLR_Y_LAST) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else if (clr_x_q == CLR_X_LAST) begin
          clr_x_d    = '0;
          clr_y_d    = clr_y_q + 7'd1;
          emit_clear = 1'b1;
        end else begin
          clr_x_d    = clr_x_q + 8'd1;
          emit_clear = 1'b1;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Sums are 9 bits wide so blocks hanging off the right edge are clipped, not wrapped.
    if (emit_draw) begin
      x_sum    = {1'b0, x_arr[idx_d]} + 9'(col_d);
      y_sum    = 9'(NOTE_Y) + 9'(row_d);
      out_x_d  = x_sum[7:0];
      out_y_d  = y_sum[6:0];
      colour_d = c_arr[idx_d];
`ifdef NOTE_OUTLINE_EN
      if (col_d == '0 || col_d == COL_LAST || row_d == '0 || row_d == ROW_LAST) begin
        colour_d = 3'b111;
      end
`else
`endif
      plot_d   = src_valid[idx_d] && (x_sum < 9'(SCR_W)) && (y_sum < 9'(SCR_H));
    end

    if (emit_clear) begin
      out_x_d  = clr_x_d;
      out_y_d  = clr_y_d;
      colour_d = BG_COLOUR;
      plot_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      mode_q        <= 1'b0;
      note_x_q      <= '0;
      note_colour_q <= '0;
      note_valid_q  <= '0;
      idx_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
      clr_x_q       <= '0;
      clr_y_q       <= '0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      colour_q      <= '0;
      plot_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      note_x_q      <= note_x_d;
      note_colour_q <= note_colour_d;
      note_valid_q  <= note_valid_d;
      idx_q         <= idx_d;
      col_q         <= col_d;
      row_q         <= row_d;
      clr_x_q       <= clr_x_d;
      clr_y_q       <= clr_y_d;
      out_x_q       <= out_x_d;
      out_y_q       <= out_y_d;
      colour_q      <= colour_d;
      plot_q        <= plot_d;
      done_q        <= done_d;
    end
  end

  assign bus.out_x  = out_x_q;
  assign bus.out_y  = out_y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: doc/note_block_plotter.md
NOTE_BLOCK_PLOTTER -- requirements
Module: note_block_plotter

Interface
REQ-001 SHALL have parameter NUM_NOTES, default 15, number of note channels.
REQ-002 SHALL have parameter BLK_W, default 4, block width in pixels (power of 2).
REQ-003 SHALL have parameter BLK_H, default 4, block height in pixels (power of 2).
REQ-004 SHALL have parameter NOTE_Y, default 110, top row of every note block.
REQ-005 SHALL have parameters SCR_W (default 160) and SCR_H (default 120), screen size in pixels.
REQ-006 SHALL have parameter BG_COLOUR, default 3'b000, the clear colour.
REQ-007 SHALL have port CLK, input, 1 bit, the single clock.
REQ-008 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1 bit, one-cycle request to begin a frame operation.
REQ-010 SHALL have port mode, input, 1 bit: 0 draws notes, 1 clears the screen.
REQ-011 SHALL have port note_x, input, NUM_NOTES*8 bits, left X of note i in bits [8i+7:8i].
REQ-012 SHALL have port note_colour, input, NUM_NOTES*3 bits, colour of note i in bits [3i+2:3i].
REQ-013 SHALL have port note_valid, input, NUM_NOTES bits; a cleared bit means note i is skipped.
REQ-014 SHALL have ports out_x (output, 8), out_y (output, 7) and colour (output, 3), all registered pixel outputs.
REQ-015 SHALL have ports plot (output, 1), busy (output, 1) and done (output, 1); plot is the pixel write strobe and done is a one-cycle completion pulse.

Function
REQ-016 SHALL implement the FSM states IDLE, DRAW, CLEAR and FINISH.
REQ-017 SHALL, in IDLE, accept start and go to DRAW if mode=0 or to CLEAR if mode=1, capturing mode, note_x, note_colour and note_valid into internal registers.
REQ-018 SHALL ignore start in any state other than IDLE, and later input changes SHALL NOT affect a frame that is in progress.
REQ-019 SHALL hold busy=1 in DRAW, CLEAR and FINISH, and busy=0 in IDLE.
REQ-020 SHALL, in DRAW, visit notes in index order 0..NUM_NOTES-1, and within a note scan pixels in row-major order: column 0..BLK_W-1 fastest, then row 0..BLK_H-1.
REQ-021 SHALL output, for each visited pixel, out_x=note_x[i]+col, out_y=NOTE_Y+row and colour=note_colour[i], with plot=1.
REQ-022 SHALL spend exactly one cycle on an invalid note, with plot=0 and no pixel emitted.
REQ-023 SHALL force plot=0 when note_x+col >= SCR_W or NOTE_Y+row >= SCR_H; this check SHALL use 9-bit addition so the sum never wraps.
REQ-024 SHALL, in CLEAR, scan out_x 0..SCR_W-1 fastest and out_y 0..SCR_H-1, with colour=BG_COLOUR and plot=1, for exactly SCR_W*SCR_H cycles.
REQ-025 SHALL, after the last pixel of DRAW or CLEAR, enter FINISH for one cycle and assert done=1 with plot=0, then return to IDLE.
REQ-026 SHALL register its outputs so that the first plot appears in the cycle after start is sampled.
REQ-027 SHALL produce a total DRAW length of (valid notes x BLK_W*BLK_H) + invalid notes cycles.
REQ-028 SHALL produce no output changes in IDLE other than holding the last out_x, out_y and colour, with plot=0.

Reset
REQ-029 SHALL, while reset=0, immediately force state IDLE, out_x=0, out_y=0, colour=0, plot=0, busy=0, done=0 and clear all counters.
REQ-030 SHALL abort any frame when reset is asserted mid-frame, with no done pulse, and on release SHALL wait in IDLE for a new start.

Configuration
REQ-031 SHALL, when NOTE_OUTLINE_EN is defined, colour the pixels with row 0, row BLK_H-1, col 0 or col BLK_W-1 as 3'b111 and the interior as note_colour.
REQ-032 SHALL, when NOTE_OUTLINE_EN is not defined, draw every block pixel in note_colour.

Verification
REQ-033 SHALL verify: defaults, all valid, note_x[i]=10*i, start mode=0 -> 240 plot pulses; first pixel (0,110); last pixel (143,113); done pulses at cycle 241.
REQ-034 SHALL verify: note_valid=15'h0001 -> 16 plots followed by 14 idle cycles, then done.
REQ-035 SHALL verify: note_x[0]=158 -> columns 2 and 3 give plot=0 and out_x=160/161 is never plotted.
REQ-036 SHALL verify: start mode=1 -> 19200 plots with colour 000, last pixel (159,119), then a done pulse.
REQ-037 SHALL verify: reset asserted at pixel 50 of a CLEAR -> all outputs are 0 in the same cycle, done never pulses, and a restart after release begins at (0,0).
REQ-038 SHALL verify: start while busy is ignored; with NOTE_OUTLINE_EN, note colour 010 -> pixel (col 1, row 1) colour 010 and pixel (col 0, row 0) colour 111.
